// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - shared types and encodings for the multicycle control unit
// MC_JUMP_EN adds the JAL/JALR states and the jump opcodes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ULAWB,
    S_BRANCH
`ifdef MC_JUMP_EN
    , S_JAL,
    S_JALR
`endif
  } state_t;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
`ifdef MC_JUMP_EN
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
`endif

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b101;
  localparam logic [2:0] ULA_BAD = 3'b100;

  localparam logic [1:0] RES_ULAOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ULARESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
`ifdef MC_JUMP_EN
  localparam logic [1:0] IMM_J = 2'b11;
`endif

endpackage

// File: rtl/multicycle_control_unit_ula_decoder.sv
// rtl/multicycle_control_unit_ula_decoder.sv - R-type {funct3, funct7[5]} to ULA operation mapping
module ula_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] ulacontrol
);

  always_comb begin
    ulacontrol = ULA_BAD;
    case ({funct3, funct7_5})
      4'b0000: ulacontrol = ULA_ADD;
      4'b0001: ulacontrol = ULA_SUB;
      4'b1110: ulacontrol = ULA_AND;
      4'b1100: ulacontrol = ULA_OR;
      4'b0100: ulacontrol = ULA_SLT;
      default: ulacontrol = ULA_BAD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RISC-V control FSM with memory wait stretching
// Define MC_JUMP_EN to support jal/jalr; otherwise both decode as illegal.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ULASrcA,
  output logic [1:0] ULASrcB,
  output logic [2:0] ULAControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       Illegal
);

  state_t     state, next_state;
  logic [3:0] cnt;
  logic       last;
  logic       taken;
  logic [2:0] ula_r;
  logic       unused_funct7;

  assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};
  assign last = (cnt == 4'(MEM_LAT - 1));

  ula_decoder u_ula_decoder (
    .funct3    (Funct3),
    .funct7_5  (Funct7[5]),
    .ulacontrol(ula_r)
  );

  always_comb begin
    case (Funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      default: taken = 1'b0;
    endcase
  end

  // Counter restarts on every state change; only the wait states ever dwell.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= (next_state != state) ? 4'd0 : cnt + 4'd1;
    end
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ULAOUT;
    ULASrcA    = SRCA_PC;
    ULASrcB    = SRCB_RS2;
    ULAControl = ULA_ADD;
    ImmSrc     = IMM_I;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ULASrcB   = SRCB_FOUR;
        ResultSrc = RES_ULARESULT;
        IRWrite   = last;
        PCWrite   = last;
        if (last) next_state = S_DECODE;
      end
      S_DECODE: begin
        ULASrcA = SRCA_OLDPC;
        ULASrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        case (Op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_B:         next_state = S_BRANCH;
`ifdef MC_JUMP_EN
          OP_JAL: begin
            ImmSrc     = IMM_J;
            next_state = S_JAL;
          end
          OP_JALR:      next_state = S_JALR;
`endif
          default: begin
            Illegal    = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ULASrcA    = SRCA_RS1;
        ULASrcB    = SRCB_IMM;
        ImmSrc     = (Op == OP_SW) ? IMM_S : IMM_I;
        next_state = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (last) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = last;
        if (last) next_state = S_FETCH;
      end
      S_EXECR: begin
        ULASrcA    = SRCA_RS1;
        ULAControl = ula_r;
        next_state = S_ULAWB;
      end
      S_EXECI: begin
        ULASrcA    = SRCA_RS1;
        ULASrcB    = SRCB_IMM;
        next_state = S_ULAWB;
      end
      S_ULAWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ULASrcA    = SRCA_RS1;
        ULAControl = ULA_SUB;
        PCWrite    = taken;
        next_state = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JAL: begin
        ULASrcA    = SRCA_OLDPC;
        ULASrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        next_state = S_ULAWB;
      end
      S_JALR: begin
        ULASrcA    = SRCA_RS1;
        ULASrcB    = SRCB_IMM;
        PCWrite    = 1'b1;
        next_state = S_ULAWB;
      end
`endif
      default: next_state = S_FETCH;
    endcase
    // Reset overrides everything: no strobes, selects parked at FETCH values.
    if (reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      Illegal    = 1'b0;
      ResultSrc  = RES_ULARESULT;
      ULASrcA    = SRCA_PC;
      ULASrcB    = SRCB_FOUR;
      ULAControl = ULA_ADD;
      ImmSrc     = IMM_I;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

  localparam int L = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Op, Funct7;
  logic [2:0] Funct3;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ULASrcA, ULASrcB, ImmSrc;
  logic [2:0] ULAControl;

  typedef struct packed {
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb;
    logic [2:0] uc;
    logic [1:0] imm;
    logic       rw, ill;
  } exp_t;

  exp_t q[$];
  exp_t act;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_unit #(.MEM_LAT(L)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct3(Funct3), .Funct7(Funct7), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .ULAControl(ULAControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  always_comb act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ULASrcA, ULASrcB,
                     ULAControl, ImmSrc, RegWrite, Illegal};

  function automatic exp_t fetch_cyc(input bit lastc);
    exp_t e = '0;
    e.rs  = 2'b10;
    e.sb  = 2'b10;
    e.irw = lastc;
    e.pcw = lastc;
    return e;
  endfunction

  function automatic exp_t ulawb_cyc();
    exp_t e = '0;
    e.rw = 1'b1;
    return e;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic b5);
    case ({f3, b5})
      4'b0000: return 3'b000;
      4'b0001: return 3'b001;
      4'b1110: return 3'b010;
      4'b1100: return 3'b011;
      4'b0100: return 3'b101;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_push(input logic [6:0] op, input logic [2:0] f3, input logic b5, input logic z);
    exp_t e, dec;
    bit   jump_en = 1'b0;
`ifdef MC_JUMP_EN
    jump_en = 1'b1;
`endif
    for (int i = 0; i < L; i++) q.push_back(fetch_cyc(i == L - 1));
    dec = '0; dec.sa = 2'b01; dec.sb = 2'b01; dec.imm = 2'b10;
    if (op == 7'b0000011) begin
      q.push_back(dec);
      e = '0; e.sa = 2'b10; e.sb = 2'b01; q.push_back(e);
      for (int i = 0; i < L; i++) begin e = '0; e.adr = 1'b1; q.push_back(e); end
      e = '0; e.rs = 2'b01; e.rw = 1'b1; q.push_back(e);
    end else if (op == 7'b0100011) begin
      q.push_back(dec);
      e = '0; e.sa = 2'b10; e.sb = 2'b01; e.imm = 2'b01; q.push_back(e);
      for (int i = 0; i < L; i++) begin e = '0; e.adr = 1'b1; e.mw = (i == L - 1); q.push_back(e); end
    end else if (op == 7'b0110011) begin
      q.push_back(dec);
      e = '0; e.sa = 2'b10; e.uc = ref_alu(f3, b5); q.push_back(e);
      q.push_back(ulawb_cyc());
    end else if (op == 7'b0010011) begin
      q.push_back(dec);
      e = '0; e.sa = 2'b10; e.sb = 2'b01; q.push_back(e);
      q.push_back(ulawb_cyc());
    end else if (op == 7'b1100011) begin
      q.push_back(dec);
      e = '0; e.sa = 2'b10; e.uc = 3'b001;
      e.pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
      q.push_back(e);
    end else if (jump_en && op == 7'b1101111) begin
      dec.imm = 2'b11; q.push_back(dec);
      e = '0; e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; q.push_back(e);
      q.push_back(ulawb_cyc());
    end else if (jump_en && op == 7'b1100111) begin
      q.push_back(dec);
      e = '0; e.sa = 2'b10; e.sb = 2'b01; e.pcw = 1'b1; q.push_back(e);
      q.push_back(ulawb_cyc());
    end else begin
      dec.ill = 1'b1; q.push_back(dec);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int   n = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, n, act, e);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic z, input string tag);
    Op = op; Funct3 = f3; Funct7 = f7; Zero = z;
    #1;
    model_push(op, f3, f7[5], z);
    drain(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1; Op = '0; Funct3 = '0; Funct7 = '0; Zero = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (act !== fetch_cyc(1'b0)) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", act, fetch_cyc(1'b0));
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ULASrcB !== 2'b10 || IRWrite !== (L == 1)) begin
      errors++;
      $display("FAIL reset_release: got ULASrcB=%b IRWrite=%b expected 10 %b", ULASrcB, IRWrite, L == 1);
    end
  endtask

  task automatic test_alu();
    run(7'b0110011, 3'b000, 7'h00, 1'b0, "add");
    run(7'b0110011, 3'b000, 7'h20, 1'b0, "sub");
    run(7'b0110011, 3'b111, 7'h00, 1'b0, "and");
    run(7'b0110011, 3'b110, 7'h00, 1'b0, "or");
    run(7'b0110011, 3'b010, 7'h00, 1'b0, "slt");
    run(7'b0110011, 3'b100, 7'h00, 1'b0, "xor_invalid");
    run(7'b0010011, 3'b000, 7'h20, 1'b1, "addi");
  endtask

  task automatic test_memory();
    run(7'b0000011, 3'b010, 7'h00, 1'b0, "lw");
    run(7'b0100011, 3'b010, 7'h00, 1'b1, "sw");
  endtask

  task automatic test_branch();
    run(7'b1100011, 3'b000, 7'h00, 1'b1, "beq_z1");
    run(7'b1100011, 3'b000, 7'h00, 1'b0, "beq_z0");
    run(7'b1100011, 3'b001, 7'h00, 1'b0, "bne_z0");
    run(7'b1100011, 3'b001, 7'h00, 1'b1, "bne_z1");
    run(7'b1100011, 3'b100, 7'h00, 1'b1, "blt_never");
  endtask

  task automatic test_illegal_and_jumps();
    run(7'b1111111, 3'b000, 7'h00, 1'b0, "illegal");
    run(7'b1101111, 3'b000, 7'h00, 1'b0, "jal");
    run(7'b1100111, 3'b000, 7'h00, 1'b0, "jalr");
  endtask

  // Stop one cycle short of the final strobe, then reset must suppress it.
  task automatic test_reset_mid();
    logic [6:0] ops [2] = '{7'b0100011, 7'b0110011};
    for (int k = 0; k < 2; k++) begin
      Op = ops[k]; Funct3 = 3'b000; Funct7 = 7'h00; Zero = 1'b0;
      #1;
      model_push(ops[k], 3'b000, 1'b0, 1'b0);
      void'(q.pop_back());
      drain("abort_prefix");
      reset = 1'b1;
      #1;
      checks++;
      if (act !== fetch_cyc(1'b0)) begin
        errors++;
        $display("FAIL reset_mid op=%b: got %h expected %h", ops[k], act, fetch_cyc(1'b0));
      end
      @(negedge clk);
      reset = 1'b0;
      run(7'b0110011, 3'b110, 7'h00, 1'b0, "after_abort");
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1111111, 7'b1101111, 7'b1100111};
    for (int i = 0; i < 24; i++) begin
      run(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
          1'($urandom_range(0, 1)), "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_branch();
    test_illegal_and_jumps();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
